retire_rat: RTL and testbench

RETIRE_RAT -- requirements
Module: retire_rat

---
 rtl/retire_rat.sv | 70 +++++++
 tb/tb_retire_rat.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/retire_rat.sv
// Retirement RAT: committed ARN->PRN map, per-way free of the displaced PRN, recovery pulse on nuke.
// Latency: one cycle from commit to arch_map/free_*/recover_valid; all outputs registered.
// No backpressure: every commit is absorbed each cycle. Optional RRAT_X0_FILTER_EN pins ARN 0 to PRN 0.
`ifndef WAYS
`define WAYS 3
`endif
`ifndef REGS
`define REGS 32
`endif
`ifndef PRF
`define PRF 64
`endif

module retire_rat (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [`WAYS-1:0]                     commit_valid,
  input  logic [`WAYS-1:0][4:0]                commit_ARN,
  input  logic [`WAYS-1:0][$clog2(`PRF)-1:0]   commit_PRN,
  input  logic                                 proc_nuke,
  output logic [`WAYS-1:0][$clog2(`PRF)-1:0]   free_PRN,
  output logic [`WAYS-1:0]                     free_valid,
  output logic [`REGS-1:0][$clog2(`PRF)-1:0]   arch_map,
  output logic                                 recover_valid
);

  localparam int PW = $clog2(`PRF);

  logic [`REGS-1:0][PW-1:0] map_n;
  logic [`WAYS-1:0][PW-1:0] free_n;

  // Walking ways in order makes each way see the PRN left by the latest
  // earlier way with the same ARN, which naturally forms same-group chains.
  always_comb begin
    map_n  = arch_map;
    free_n = '0;
    for (int j = 0; j < `WAYS; j++) begin
      if (commit_valid[j]) begin
`ifdef RRAT_X0_FILTER_EN
        if (commit_ARN[j] == 5'd0) begin
          free_n[j] = commit_PRN[j];
        end else begin
          free_n[j]               = map_n[commit_ARN[j]];
          map_n[commit_ARN[j]]    = commit_PRN[j];
        end
`else
        free_n[j]            = map_n[commit_ARN[j]];
        map_n[commit_ARN[j]] = commit_PRN[j];
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < `REGS; i++) begin
        arch_map[i] <= PW'(i);
      end
      free_PRN      <= '0;
      free_valid    <= '0;
      recover_valid <= 1'b0;
    end else begin
      arch_map      <= map_n;
      free_PRN      <= free_n;
      free_valid    <= commit_valid;
      recover_valid <= proc_nuke;
    end
  end

endmodule

// File: tb/tb_retire_rat.sv
// Randomized bench for retire_rat against an array-based reference model.
`ifndef WAYS
`define WAYS 3
`endif
`ifndef REGS
`define REGS 32
`endif
`ifndef PRF
`define PRF 64
`endif

module tb_retire_rat;

  localparam int PW = $clog2(`PRF);

  logic                           clock;
  logic                           reset;
  logic [`WAYS-1:0]               commit_valid;
  logic [`WAYS-1:0][4:0]          commit_ARN;
  logic [`WAYS-1:0][PW-1:0]       commit_PRN;
  logic                           proc_nuke;
  logic [`WAYS-1:0][PW-1:0]       free_PRN;
  logic [`WAYS-1:0]               free_valid;
  logic [`REGS-1:0][PW-1:0]       arch_map;
  logic                           recover_valid;

  retire_rat dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_ARN   (commit_ARN),
    .commit_PRN   (commit_PRN),
    .proc_nuke    (proc_nuke),
    .free_PRN     (free_PRN),
    .free_valid   (free_valid),
    .arch_map     (arch_map),
    .recover_valid(recover_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  int mm [`REGS];
  int exp_fp [`WAYS];
  int exp_fv [`WAYS];
  int exp_rec;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit filtered(input int arn);
`ifdef RRAT_X0_FILTER_EN
    return arn == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_all();
    for (int j = 0; j < `WAYS; j++) begin
      check($sformatf("free_valid%0d", j), 64'(free_valid[j]), 64'(exp_fv[j]));
      check($sformatf("free_prn%0d", j), 64'(free_PRN[j]), 64'(exp_fp[j]));
    end
    check("recover_valid", 64'(recover_valid), 64'(exp_rec));
    for (int i = 0; i < `REGS; i++)
      check($sformatf("map%0d", i), 64'(arch_map[i]), 64'(mm[i]));
  endtask

  // Apply one cycle of inputs, advance the model, then sample after the edge.
  task automatic step(input logic [`WAYS-1:0] v, input logic [`WAYS-1:0][4:0] a,
                      input logic [`WAYS-1:0][PW-1:0] p, input logic nk, input logic rs);
    int old;
    commit_valid = v;
    commit_ARN   = a;
    commit_PRN   = p;
    proc_nuke    = nk;
    reset        = rs;
    if (rs) begin
      for (int i = 0; i < `REGS; i++) mm[i] = i;
      for (int j = 0; j < `WAYS; j++) begin exp_fp[j] = 0; exp_fv[j] = 0; end
      exp_rec = 0;
    end else begin
      for (int j = 0; j < `WAYS; j++) begin
        exp_fv[j] = int'(v[j]);
        exp_fp[j] = 0;
        if (v[j]) begin
          if (filtered(int'(a[j]))) begin
            exp_fp[j] = int'(p[j]);
          end else begin
            old = mm[a[j]];
            for (int k = 0; k < j; k++)
              if (v[k] && a[k] == a[j]) old = int'(p[k]);
            exp_fp[j] = old;
          end
        end
      end
      for (int j = 0; j < `WAYS; j++)
        if (v[j] && !filtered(int'(a[j]))) mm[a[j]] = int'(p[j]);
      exp_rec = int'(nk);
    end
    @(posedge clock);
    #1;
    compare_all();
  endtask

  initial begin
    logic [`WAYS-1:0]         rv;
    logic [`WAYS-1:0][4:0]    ra;
    logic [`WAYS-1:0][PW-1:0] rp;
    int n;

    commit_valid = '0; commit_ARN = '0; commit_PRN = '0; proc_nuke = 1'b0; reset = 1'b1;
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b0);
    check("idle_map5", 64'(arch_map[5]), 64'd5);
    check("idle_map31", 64'(arch_map[31]), 64'd31);

    step(3'b111, {5'd9, 5'd7, 5'd3}, {PW'(42), PW'(41), PW'(40)}, 1'b0, 1'b0);
    check("three_map3", 64'(arch_map[3]), 64'd40);
    check("three_free2", 64'(free_PRN[2]), 64'd9);

    step('0, '0, '0, 1'b0, 1'b1);
    step(3'b111, {5'd4, 5'd4, 5'd4}, {PW'(52), PW'(51), PW'(50)}, 1'b0, 1'b0);
    check("chain_free1", 64'(free_PRN[1]), 64'd50);
    check("chain_map4", 64'(arch_map[4]), 64'd52);

    step(3'b011, {5'd0, 5'd6, 5'd2}, {PW'(0), PW'(34), PW'(33)}, 1'b1, 1'b0);
    check("nuke_rec", 64'(recover_valid), 64'd1);
    step('0, '0, '0, 1'b0, 1'b0);
    check("nuke_rec_drop", 64'(recover_valid), 64'd0);

    step(3'b001, {5'd0, 5'd0, 5'd0}, {PW'(0), PW'(0), PW'(60)}, 1'b0, 1'b0);
`ifdef RRAT_X0_FILTER_EN
    check("x0_map0", 64'(arch_map[0]), 64'd0);
    check("x0_free0", 64'(free_PRN[0]), 64'd60);
`else
    check("x0_map0", 64'(arch_map[0]), 64'd60);
    check("x0_free0", 64'(free_PRN[0]), 64'd0);
`endif

    step(3'b111, {5'd1, 5'd2, 5'd3}, {PW'(10), PW'(11), PW'(12)}, 1'b1, 1'b1);
    check("rst_dom_map3", 64'(arch_map[3]), 64'd3);
    check("rst_dom_rec", 64'(recover_valid), 64'd0);

    step(3'b000, '0, '0, 1'b1, 1'b0);
    step(3'b000, '0, '0, 1'b1, 1'b0);

    for (int it = 0; it < 400; it++) begin
      n = $urandom_range(0, `WAYS);
      rv = '0;
      for (int j = 0; j < `WAYS; j++) begin
        if (j < n) rv[j] = 1'b1;
        ra[j] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        rp[j] = PW'($urandom_range(0, `PRF - 1));
      end
      step(rv, ra, rp, ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
